mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch/data) memory port arbiter with anti-starvation for fetch
// and a per-transaction acknowledge timeout that reports bus_err.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              bus_err
);

    localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);
    localparam int unsigned WaitW   = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

    state_e              state_q, state_d;
    logic [StarveW-1:0]  starve_cnt_q, starve_cnt_d;
    logic [WaitW-1:0]    wait_cnt_q, wait_cnt_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                i_ack_q, i_ack_d;
    logic                d_ack_q, d_ack_d;
    logic                bus_err_q, bus_err_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

    logic starve_max;
    logic fetch_wins;
    logic timeout;

    assign starve_max = (starve_cnt_q == StarveW'(STARVE_MAX));
    // Arbitrate on raw levels; a winner whose ack is still high is simply not granted.
    assign fetch_wins = i_req && (!d_req || starve_max);
    assign timeout    = !mem_ack && (wait_cnt_q == WaitW'(TIMEOUT - 1));

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        i_ack_d      = 1'b0;
        d_ack_d      = 1'b0;
        bus_err_d    = 1'b0;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (fetch_wins) begin
                    if (!i_ack_q) begin
                        state_d      = StBusyI;
                        mem_req_d    = 1'b1;
                        mem_we_d     = 1'b0;
                        mem_addr_d   = i_addr;
                        mem_wdata_d  = '0;
                        wait_cnt_d   = '0;
                        starve_cnt_d = '0;
                    end
                end else if (d_req && !d_ack_q) begin
                    state_d     = StBusyD;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    wait_cnt_d  = '0;
                    if (i_req && !starve_max) begin
                        starve_cnt_d = starve_cnt_q + StarveW'(1);
                    end
                end
            end
            StBusyI, StBusyD: begin
                if (mem_ack || timeout) begin
                    state_d   = StIdle;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    bus_err_d = !mem_ack;
                    if (state_q == StBusyI) begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = mem_ack ? mem_rdata : '1;
                    end else begin
                        d_ack_d = 1'b1;
                        if (!mem_we_q) begin
                            d_rdata_d = mem_ack ? mem_rdata : '1;
                        end
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + WaitW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            starve_cnt_q <= '0;
            wait_cnt_q   <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            i_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
            bus_err_q    <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            i_ack_q      <= i_ack_d;
            d_ack_q      <= d_ack_d;
            bus_err_q    <= bus_err_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign i_ack     = i_ack_q;
    assign i_rdata   = i_rdata_q;
    assign d_ack     = d_ack_q;
    assign d_rdata   = d_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table plus hand-written
// sequences for starvation order, timeout, ack-on-timeout and mid-transaction reset.
module tb_mem_port_arbiter;

    localparam logic [31:0] IAddr = 32'h0000_0100;
    localparam logic [31:0] DAddr = 32'h0000_0020;
    localparam logic [31:0] WData = 32'h1234_5678;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = IAddr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = DAddr;
    logic [31:0] d_wdata = WData;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        bus_err;

    mem_port_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .STARVE_MAX(4),
        .TIMEOUT   (15)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_ack    (i_ack),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ack    (d_ack),
        .d_rdata  (d_rdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .bus_err  (bus_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic both_acks_seen = 1'b0;

    always @(negedge clk) begin
        if (i_ack && d_ack) both_acks_seen = 1'b1;
    end

    typedef struct {
        logic        i_req;
        logic        d_req;
        logic        d_we;
        logic        mem_ack;
        logic [31:0] mem_rdata;
        logic        e_mem_req;
        logic        e_mem_we;
        logic [31:0] e_mem_addr;
        logic        e_i_ack;
        logic        e_d_ack;
        logic [31:0] e_i_rdata;
        logic [31:0] e_d_rdata;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n   = 1'b0;
        i_req   = 1'b0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(input logic ir, input logic dr, input logic we, input logic ack,
                                input logic [31:0] rd, input logic emr, input logic emw,
                                input logic [31:0] ea, input logic eia, input logic eda,
                                input logic [31:0] eir, input logic [31:0] edr);
        vec_t v;
        v.i_req = ir; v.d_req = dr; v.d_we = we; v.mem_ack = ack; v.mem_rdata = rd;
        v.e_mem_req = emr; v.e_mem_we = emw; v.e_mem_addr = ea;
        v.e_i_ack = eia; v.e_d_ack = eda; v.e_i_rdata = eir; v.e_d_rdata = edr;
        return v;
    endfunction

    logic grant_is_i[10];
    int   n_grants;
    int   cyc;
    logic quiet;

    initial begin
        // Each row: inputs held over one edge, then outputs expected just after it.
        vecs[0]  = mk(1, 0, 0, 0, 32'h0,         1, 0, IAddr, 0, 0, 32'h0,         32'h0);
        vecs[1]  = mk(1, 0, 0, 1, 32'hDEADBEEF,  0, 0, IAddr, 1, 0, 32'hDEADBEEF,  32'h0);
        vecs[2]  = mk(1, 0, 0, 0, 32'h0,         0, 0, IAddr, 0, 0, 32'hDEADBEEF,  32'h0);
        vecs[3]  = mk(0, 1, 1, 0, 32'h0,         1, 1, DAddr, 0, 0, 32'hDEADBEEF,  32'h0);
        vecs[4]  = mk(0, 1, 1, 0, 32'h0,         1, 1, DAddr, 0, 0, 32'hDEADBEEF,  32'h0);
        vecs[5]  = mk(0, 1, 1, 1, 32'hAAAA5555,  0, 0, DAddr, 0, 1, 32'hDEADBEEF,  32'h0);
        vecs[6]  = mk(0, 1, 1, 0, 32'h0,         0, 0, DAddr, 0, 0, 32'hDEADBEEF,  32'h0);
        vecs[7]  = mk(0, 1, 0, 0, 32'h0,         1, 0, DAddr, 0, 0, 32'hDEADBEEF,  32'h0);
        vecs[8]  = mk(0, 1, 0, 1, 32'h0BADF00D,  0, 0, DAddr, 0, 1, 32'hDEADBEEF,  32'h0BADF00D);
        vecs[9]  = mk(0, 0, 0, 1, 32'h11111111,  0, 0, DAddr, 0, 0, 32'hDEADBEEF,  32'h0BADF00D);
        vecs[10] = mk(1, 0, 0, 0, 32'h0,         1, 0, IAddr, 0, 0, 32'hDEADBEEF,  32'h0BADF00D);

        // Reset values, checked while rst_n is still low.
        #2;
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_acks", {30'h0, i_ack, d_ack}, 32'h0);
        check("rst_bus_err", 32'(bus_err), 32'h0);
        check("rst_i_rdata", i_rdata, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);

        reset_dut();
        for (int k = 0; k < 11; k++) begin
            i_req     = vecs[k].i_req;
            d_req     = vecs[k].d_req;
            d_we      = vecs[k].d_we;
            mem_ack   = vecs[k].mem_ack;
            mem_rdata = vecs[k].mem_rdata;
            step();
            check($sformatf("vec%0d_mem_req", k), 32'(mem_req), 32'(vecs[k].e_mem_req));
            check($sformatf("vec%0d_mem_we", k), 32'(mem_we), 32'(vecs[k].e_mem_we));
            check($sformatf("vec%0d_i_ack", k), 32'(i_ack), 32'(vecs[k].e_i_ack));
            check($sformatf("vec%0d_d_ack", k), 32'(d_ack), 32'(vecs[k].e_d_ack));
            check($sformatf("vec%0d_i_rdata", k), i_rdata, vecs[k].e_i_rdata);
            check($sformatf("vec%0d_d_rdata", k), d_rdata, vecs[k].e_d_rdata);
            check($sformatf("vec%0d_bus_err", k), 32'(bus_err), 32'h0);
            if (vecs[k].e_mem_req) begin
                check($sformatf("vec%0d_mem_addr", k), mem_addr, vecs[k].e_mem_addr);
                if (vecs[k].e_mem_we || vecs[k].e_mem_addr == IAddr)
                    check($sformatf("vec%0d_mem_wdata", k), mem_wdata,
                          vecs[k].e_mem_we ? WData : 32'h0);
            end
        end
        mem_ack = 1'b0;

        // Both requesters held, memory acks the cycle after each request.
        reset_dut();
        i_req    = 1'b1;
        d_req    = 1'b1;
        d_we     = 1'b0;
        n_grants = 0;
        cyc      = 0;
        while (n_grants < 10 && cyc < 80) begin
            mem_ack   = mem_req;
            mem_rdata = 32'h0000_0042;
            step();
            cyc++;
            if (mem_req) begin
                grant_is_i[n_grants] = (mem_addr == IAddr);
                n_grants++;
            end
        end
        check("starve_grant_count", n_grants, 10);
        for (int k = 0; k < n_grants; k++)
            check($sformatf("starve_grant%0d_is_fetch", k), 32'(grant_is_i[k]),
                  32'(k % 5 == 4));
        i_req   = 1'b0;
        d_req   = 1'b0;
        mem_ack = 1'b0;

        // Data read with no mem_ack: timeout after the 15th busy cycle.
        reset_dut();
        d_req     = 1'b1;
        d_we      = 1'b0;
        mem_rdata = 32'h0;
        step();
        check("to_grant", 32'(mem_req), 32'h1);
        quiet = 1'b1;
        for (int k = 1; k < 15; k++) begin
            step();
            if (!(mem_req && !d_ack && !bus_err)) quiet = 1'b0;
        end
        check("to_waiting", 32'(quiet), 32'h1);
        step();
        check("to_d_ack", 32'(d_ack), 32'h1);
        check("to_bus_err", 32'(bus_err), 32'h1);
        check("to_d_rdata", d_rdata, 32'hFFFF_FFFF);
        check("to_mem_req", 32'(mem_req), 32'h0);
        d_req = 1'b0;
        step();
        check("to_after_pulse", {29'h0, bus_err, d_ack, mem_req}, 32'h0);

        // Fresh read, mem_ack arrives on exactly the timeout cycle.
        d_req = 1'b1;
        step();
        check("ackto_grant", 32'(mem_req), 32'h1);
        for (int k = 1; k < 15; k++) step();
        mem_ack   = 1'b1;
        mem_rdata = 32'h5A5A_5A5A;
        step();
        check("ackto_d_ack", 32'(d_ack), 32'h1);
        check("ackto_bus_err", 32'(bus_err), 32'h0);
        check("ackto_d_rdata", d_rdata, 32'h5A5A_5A5A);
        mem_ack = 1'b0;
        d_req   = 1'b0;
        step();
        mem_ack   = 1'b1;
        mem_rdata = 32'h7777_7777;
        step();
        check("stray_outputs", {28'h0, i_ack, d_ack, bus_err, mem_req}, 32'h0);
        check("stray_d_rdata", d_rdata, 32'h5A5A_5A5A);
        mem_ack = 1'b0;
        step();
        check("stray_quiet", {28'h0, i_ack, d_ack, bus_err, mem_req}, 32'h0);

        // Reset pulsed low during a fetch.
        reset_dut();
        i_req = 1'b1;
        step();
        check("rstmid_grant", 32'(mem_req), 32'h1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h9999_9999;
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_mem_req_async", 32'(mem_req), 32'h0);
        step();
        check("rstmid_no_ack", {30'h0, i_ack, bus_err}, 32'h0);
        check("rstmid_i_rdata", i_rdata, 32'h0);
        mem_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("rstmid_regrant", 32'(mem_req), 32'h1);
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        step();
        check("rstmid_i_ack", 32'(i_ack), 32'h1);
        check("rstmid_i_rdata_new", i_rdata, 32'hCAFE_F00D);
        mem_ack = 1'b0;
        i_req   = 1'b0;
        step();

        check("never_both_acks", 32'(both_acks_seen), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
